// File: rtl/prio_sel_arb.sv
// prio_sel_arb: registered N-channel priority selector with arbitration.
//
// One request channel per sel bit wins the single output register each
// time that register may be (re)loaded. The winner is chosen by MODE:
//   0 = lowest requesting index, 1 = highest requesting index,
//   2 = round-robin starting at an internal pointer.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   in_data  in   N*W channel data, channel k at [k*W +: W]
//   sel      in   N per-channel request bits
//   dflt     in   W value loaded into z when nobody requests
//   grant    out  N one-hot acknowledge, combinational
//   z        out  W registered selected data
//   z_valid  out  z holds granted channel data
//   z_ready  in   downstream accepts z this cycle
//   z_idx    out  IW registered index of the channel that produced z
module prio_sel_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int IW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     sel,
  input  logic [W-1:0]     dflt,
  output logic [N-1:0]     grant,
  output logic [W-1:0]     z,
  output logic             z_valid,
  input  logic             z_ready,
  output logic [IW-1:0]    z_idx
);

  logic          load;
  logic          any_req;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr;

  // Channel index 'off' positions after 'base', wrapping modulo N.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Pointer advance past the winner; wraps to 0 after the last channel.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
    if (w == IW'(N - 1)) return '0;
    return w + 1'b1;
  endfunction

  assign load    = !z_valid || z_ready;
  assign any_req = |sel;

  // The last assignment in each loop is the one that sticks, so the loop
  // direction decides which requester has priority.
  always_comb begin
    logic [IW-1:0] cand;
    winner = '0;
    cand   = '0;
    if (MODE == 1) begin
      for (int i = 0; i < N; i++)
        if (sel[i]) winner = IW'(i);
    end else if (MODE == 2) begin
      for (int i = N - 1; i >= 0; i--) begin
        cand = rr_index(ptr, i);
        if (sel[cand]) winner = cand;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (sel[i]) winner = IW'(i);
    end
  end

  // Grant is suppressed during reset; after async reset z_valid is 0 so
  // load alone would otherwise let a grant through.
  always_comb begin
    grant = '0;
    if (!rst && load && any_req) grant[winner] = 1'b1;
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z       <= '0;
      z_valid <= 1'b0;
      z_idx   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any_req) begin
        z       <= in_data[int'(winner)*W +: W];
        z_idx   <= winner;
        z_valid <= 1'b1;
        if (MODE == 2) ptr <= next_ptr(winner);
      end else begin
        z       <= dflt;
        z_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_sel_arb.sv
// Bench for prio_sel_arb: three instances (MODE 0, 1, 2) share one set of
// inputs; a queue-based reference model predicts each instance's outputs.
module tb_prio_sel_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       ch [N];
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     sel;
  logic [W-1:0]     dflt;
  logic             z_ready;

  logic [N-1:0]     g  [3];
  logic [W-1:0]     zo [3];
  logic             zv [3];
  logic [1:0]       zi [3];

  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    prio_sel_arb #(.N(N), .W(W), .MODE(m)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .dflt(dflt),
      .grant(g[m]), .z(zo[m]), .z_valid(zv[m]), .z_ready(z_ready), .z_idx(zi[m])
    );
  end

  // Reference model state per mode
  logic [7:0] mz [3];
  bit         mv [3];
  int         midx [3];
  int         mptr [3];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Winner from the list of requesting channels.
  function automatic int pick(int m, logic [N-1:0] s, int p);
    int q[$];
    int best, bd, d;
    for (int k = 0; k < N; k++) if (s[k]) q.push_back(k);
    if (q.size() == 0) return -1;
    if (m == 0) return q[0];
    if (m == 1) return q[q.size()-1];
    best = q[0];
    bd = N;
    foreach (q[j]) begin
      d = (q[j] - p + N) % N;
      if (d < bd) begin bd = d; best = q[j]; end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_grant(int m);
    logic [N-1:0] r;
    int w;
    r = '0;
    if (rst) return r;
    if (mv[m] && !z_ready) return r;
    w = pick(m, sel, mptr[m]);
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 3; m++) begin
        mz[m] = '0; mv[m] = 0; midx[m] = 0; mptr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 3; m++) begin
        int w;
        if (!mv[m] || z_ready) begin
          w = pick(m, sel, mptr[m]);
          if (w >= 0) begin
            mz[m] = ch[w]; midx[m] = w; mv[m] = 1;
            if (m == 2) mptr[m] = (w + 1) % N;
          end else begin
            mz[m] = dflt; mv[m] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("m%0d grant", m), 32'(g[m]), 32'(exp_grant(m)));
        chk($sformatf("m%0d z", m), 32'(zo[m]), 32'(mz[m]));
        chk($sformatf("m%0d z_valid", m), 32'(zv[m]), 32'(mv[m]));
        chk($sformatf("m%0d z_idx", m), 32'(zi[m]), 32'(midx[m]));
      end
    end
  end

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; sel = '0; z_ready = 1'b0; dflt = '0;
    ch[0] = 8'h11; ch[1] = 8'h22; ch[2] = 8'h33; ch[3] = 8'h44;
    #2;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst m%0d z", m), 32'(zo[m]), 32'h0);
      chk($sformatf("rst m%0d z_valid", m), 32'(zv[m]), 32'h0);
      chk($sformatf("rst m%0d z_idx", m), 32'(zi[m]), 32'h0);
      chk($sformatf("rst m%0d grant", m), 32'(g[m]), 32'h0);
    end
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin sweep with all channels requesting
    sel = 4'b1111; z_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr seq %0d", i), 32'(zi[2]), 32'(rr_exp[i]));
      chk($sformatf("rr model %0d", i), 32'(midx[2]), 32'(rr_exp[i]));
    end

    // Lowest vs highest index
    sel = 4'b1010;
    #1;
    chk("lo grant", 32'(g[0]), 32'h2);
    chk("hi grant", 32'(g[1]), 32'h8);
    @(posedge clk); #1;
    chk("lo z", 32'(zo[0]), 32'h22);
    chk("lo z_idx", 32'(zi[0]), 32'd1);
    chk("lo z_valid", 32'(zv[0]), 32'd1);
    chk("hi z", 32'(zo[1]), 32'h44);
    chk("hi z_idx", 32'(zi[1]), 32'd3);
    chk("hi z_valid", 32'(zv[1]), 32'd1);

    // No request: default loads, index holds
    sel = '0; dflt = 8'hA5;
    @(posedge clk); #1;
    chk("dflt z", 32'(zo[0]), 32'hA5);
    chk("dflt z_valid", 32'(zv[0]), 32'd0);
    chk("dflt z_idx", 32'(zi[0]), 32'd1);

    // Stall: output holds, grant withheld, data changes ignored
    sel = 4'b0001;
    @(posedge clk); #1;
    chk("stall load z", 32'(zo[0]), 32'h11);
    z_ready = 1'b0;
    ch[0] = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall grant", 32'(g[0]), 32'h0);
      @(posedge clk); #1;
      chk("stall z", 32'(zo[0]), 32'h11);
      chk("stall z_valid", 32'(zv[0]), 32'd1);
    end
    z_ready = 1'b1;
    #1 chk("unstall grant", 32'(g[0]), 32'h1);
    @(posedge clk); #1;
    chk("unstall z", 32'(zo[0]), 32'h99);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) ch[k] = 8'($urandom);
      sel = 4'($urandom);
      dflt = 8'($urandom);
      z_ready = ($urandom_range(0, 3) != 0);
    end

    // Reset during a round-robin stall
    @(posedge clk); #1;
    rst = 1'b1;
    #1 rst = 1'b0;
    ch[0] = 8'h11; ch[1] = 8'h22; ch[2] = 8'h33; ch[3] = 8'h44;
    sel = 4'b0010; z_ready = 1'b1;
    @(posedge clk); #1;
    chk("rr pre z_idx", 32'(zi[2]), 32'd1);
    chk("rr pre z_valid", 32'(zv[2]), 32'd1);
    z_ready = 1'b0; sel = 4'b1111;
    @(posedge clk); #1;
    chk("rr stall z_idx", 32'(zi[2]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst z", 32'(zo[2]), 32'h0);
    chk("mid rst z_valid", 32'(zv[2]), 32'd0);
    chk("mid rst z_idx", 32'(zi[2]), 32'd0);
    for (int m = 0; m < 3; m++)
      chk($sformatf("mid rst grant m%0d", m), 32'(g[m]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; sel = 4'b1111; z_ready = 1'b1;
    @(posedge clk); #1;
    chk("post rst rr z_idx", 32'(zi[2]), 32'd0);

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_sel_arb.md
Name: prio_sel_arb

Overview:
- Parametrised, registered N-channel priority selector with arbitration.
- Successor to the fixed 4-input, 1-bit combinational priority mux (default input, per-channel select bits). Generalised in channel count and data width.
- Adds three selectable priority modes (lowest-index-wins, highest-index-wins, round-robin), a one-cycle registered output stage and a valid/ready handshake with backpressure.
- Sits between multiple request sources and a single downstream consumer.

Parameters:
- N, 4: number of request channels, N >= 2.
- W, 8: data width per channel and of the output.
- MODE, 0: 0 = lowest index wins (if / else-if chain); 1 = highest index wins (sequential overriding ifs); 2 = round-robin.
- IW, $clog2(N): width of the grant index. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*W  channel data; channel k occupies bits [k*W +: W].
- sel  in  N  per-channel request (valid); bit k requests for channel k.
- dflt  in  W  default value loaded into z when no channel requests.
- grant  out  N  combinational one-hot acknowledge; the request in that bit is consumed this cycle.
- z  out  W  registered selected data.
- z_valid  out  1  z holds granted channel data.
- z_ready  in  1  downstream accepts z this cycle.
- z_idx  out  IW  registered index of the channel that produced z.

Behaviour:
- Reset (asynchronous, rst=1):
  - z=0, z_valid=0, z_idx=0.
  - Round-robin pointer ptr=0.
  - grant=0 while rst is high.
- Load enable: load = !z_valid | z_ready.
- Winner selection (combinational, over sel):
  - MODE 0: lowest set index.
  - MODE 1: highest set index.
  - MODE 2: first set index searching ptr, ptr+1, ..., wrapping mod N.
- grant = one-hot(winner) when load and |sel; otherwise 0.
- Never more than one grant bit is set.
- On a clock edge with load=1 and |sel=1:
  - z <= in_data[winner], z_idx <= winner, z_valid <= 1.
  - MODE 2 only: ptr <= (winner+1) mod N. ptr is a wrap-around counter and wraps to 0 when winner = N-1.
- On a clock edge with load=1 and sel=0:
  - z <= dflt, z_valid <= 0.
  - z_idx and ptr unchanged.
- On a clock edge with load=0 (z_valid=1, z_ready=0, stall):
  - z, z_idx, z_valid and ptr all hold.
  - grant=0. Requesters keep sel asserted and lose nothing.
- Latency: 1 cycle from the granted sel to z_valid/z.
- Throughput: 1 transfer per cycle while z_ready=1.
- Simultaneous z_ready=1 and a new request: the old z is consumed and the new winner is loaded on the same edge (no bubble).
- Requester contract: sel[k] deassertion is the requester's responsibility after grant[k]. A still-asserted sel[k] is treated as a new request.
- ptr is ignored in MODE 0 and MODE 1, but still resets to 0.
- Reset asserted mid-stall: the pending z is discarded and all outputs return to reset values immediately, without waiting for clk.
- in_data or dflt changes while stalled do not affect z.

Test Plan:
1. N=4, W=8, MODE 0, in_data={8'h44,8'h33,8'h22,8'h11}, sel=4'b1010, z_ready=1 -> grant=4'b0010; next cycle z=8'h22, z_idx=1, z_valid=1.
2. Same stimulus, MODE 1 -> grant=4'b1000; next cycle z=8'h44, z_idx=3, z_valid=1.
3. MODE 2, sel=4'b1111 held, z_ready=1 for 6 cycles -> z_idx sequence 0,1,2,3,0,1 (ptr wraps after index 3).
4. MODE 0, sel=4'b0001, z_ready=0 for 3 cycles after the first load:
   - z=8'h11 and z_valid=1 held; grant=0 during the stall.
   - z_ready=1 -> grant=4'b0001 the same cycle, and z reloads on the next edge.
5. sel=0, dflt=8'hA5, z_ready=1 -> next cycle z=8'hA5, z_valid=0, z_idx unchanged from its previous value.
6. MODE 2 stalled with z_valid=1, ptr=2; assert rst between clock edges -> z=0, z_valid=0, z_idx=0, grant=0 immediately. After release, sel=4'b1111 -> first z_idx=0.
